// File: rtl/seq_chunk_adder.sv
// Sequential chunked adder/subtractor.
// Adds CHUNK bits per cycle with a registered carry between chunks.
module seq_chunk_adder #(
    parameter int SIZE  = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    input  logic            cin,
    input  logic            sub,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] sum,
    output logic            cout,
    output logic            overflow
);

    localparam int NCHUNK = SIZE / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-1:0] acc;
    logic            carry_q;
    logic [CW-1:0]   cnt;

    logic [CHUNK-1:0] ach;
    logic [CHUNK-1:0] bch;
    logic [CHUNK:0]   csum;
    logic [SIZE-1:0]  res;
    logic             last;
    logic             load;

    // Operate on the current chunk only; the carry comes from a register.
    always_comb begin
        ach  = a_q[cnt*CHUNK +: CHUNK];
        bch  = b_q[cnt*CHUNK +: CHUNK];
        csum = {1'b0, ach} + {1'b0, bch} + {{CHUNK{1'b0}}, carry_q};
        res  = acc;
        res[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        last = (cnt == LAST);
        load = start && (state != BUSY);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? BUSY : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-chunk accumulation and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            a_q     <= x;
            b_q     <= sub ? ~y : y;
            carry_q <= sub | cin;
            cnt     <= '0;
        end else if (state == BUSY) begin
            acc     <= res;
            carry_q <= csum[CHUNK];
            cnt     <= last ? '0 : cnt + 1'b1;
            if (last) begin
                sum      <= res;
                cout     <= csum[CHUNK];
                // carry into the MSB is a^b^s at that bit
                overflow <= a_q[SIZE-1] ^ b_q[SIZE-1]
                          ^ res[SIZE-1] ^ csum[CHUNK];
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed testbench for seq_chunk_adder.
// SIZE=16, CHUNK=4.
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int checks;
    int passed;
    logic [15:0] prev;

    seq_chunk_adder #(.SIZE(16), .CHUNK(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .x(x),
        .y(y),
        .cin(cin),
        .sub(sub),
        .busy(busy),
        .done(done),
        .sum(sum),
        .cout(cout),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        x = 16'h1234;
        y = 16'h4321;
        cin = 1'b0;
        sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        checks++;
        if (done !== 1'b0)
            $display("FAIL reset_done: got %b want 0", done);
        else passed++;
        checks++;
        if (sum !== 16'h0000)
            $display("FAIL reset_sum: got %h want 0000", sum);
        else passed++;
        checks++;
        if (cout !== 1'b0)
            $display("FAIL reset_cout: got %b want 0", cout);
        else passed++;
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL reset_ovf: got %b want 0", overflow);
        else passed++;
        start = 1'b0;
        rst = 1'b0;
        prev = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_op(input string nm,
                           input logic [15:0] xa,
                           input logic [15:0] ya,
                           input logic ci,
                           input logic sb,
                           input logic [15:0] es,
                           input logic ec,
                           input logic eo);
        int ncyc;
        int nbusy;
        bit held;
        ncyc = 0;
        nbusy = 0;
        held = 1'b1;
        @(negedge clk);
        start = 1'b1;
        x = xa;
        y = ya;
        cin = ci;
        sub = sb;
        @(posedge clk);
        for (int i = 1; i <= 10 && ncyc == 0; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) ncyc = i;
            else if (sum !== prev) held = 1'b0;
        end
        checks++;
        if (ncyc != 5)
            $display("FAIL %s_latency: got %0d want 5", nm, ncyc);
        else passed++;
        checks++;
        if (nbusy != 4)
            $display("FAIL %s_busy: got %0d want 4", nm, nbusy);
        else passed++;
        checks++;
        if (!held)
            $display("FAIL %s_hold: sum changed before done want %h", nm, prev);
        else passed++;
        checks++;
        if (sum !== es)
            $display("FAIL %s_sum: got %h want %h", nm, sum, es);
        else passed++;
        checks++;
        if (cout !== ec)
            $display("FAIL %s_cout: got %b want %b", nm, cout, ec);
        else passed++;
        checks++;
        if (overflow !== eo)
            $display("FAIL %s_ovf: got %b want %b", nm, overflow, eo);
        else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_pulse: got done=%b busy=%b want 0 0",
                     nm, done, busy);
        else passed++;
        prev = es;
    endtask

    task automatic test_vectors();
        test_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_op("ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_op("cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        test_op("sub",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_op("subov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        test_op("add",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        bit gap;
        n1 = 0;
        n2 = 0;
        gap = 1'b0;
        @(negedge clk);
        start = 1'b1;
        x = 16'h1234;
        y = 16'h1111;
        cin = 1'b0;
        sub = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 10 && n1 == 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n1 = i;
                x = 16'hAAAA;
                y = 16'h5555;
                cin = 1'b0;
                sub = 1'b0;
            end else begin
                x = 16'h0F0F ^ 16'(i * 16'h1357);
                y = 16'hF00F ^ 16'(i * 16'h0911);
                cin = 1'b1;
                sub = i[0];
            end
        end
        checks++;
        if (n1 != 5 || sum !== 16'h2345 || cout !== 1'b0)
            $display("FAIL b2b_first: got n=%0d sum=%h c=%b want 5 2345 0",
                     n1, sum, cout);
        else passed++;
        for (int j = 1; j <= 10 && n2 == 0; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0;
                if (busy !== 1'b1) gap = 1'b1;
            end
            if (done === 1'b1) n2 = j;
        end
        checks++;
        if (gap)
            $display("FAIL b2b_gap: got busy=0 after done want busy=1");
        else passed++;
        checks++;
        if (n2 != 5)
            $display("FAIL b2b_latency: got %0d want 5", n2);
        else passed++;
        checks++;
        if (sum !== 16'hFFFF || cout !== 1'b0 || overflow !== 1'b0)
            $display("FAIL b2b_second: got %h %b %b want FFFF 0 0",
                     sum, cout, overflow);
        else passed++;
        prev = 16'hFFFF;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        x = 16'h7FFF;
        y = 16'h0001;
        cin = 1'b0;
        sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mrst_status: got busy=%b done=%b want 0 0",
                     busy, done);
        else passed++;
        checks++;
        if (sum !== 16'h0000)
            $display("FAIL mrst_sum: got %h want 0000", sum);
        else passed++;
        checks++;
        if (cout !== 1'b0 || overflow !== 1'b0)
            $display("FAIL mrst_flags: got c=%b o=%b want 0 0",
                     cout, overflow);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen)
            $display("FAIL mrst_nodone: got done pulse want none");
        else passed++;
        prev = 16'h0000;
        test_op("after", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        cin = 1'b0;
        sub = 1'b0;
        prev = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
